mem_arbiter2: RTL and testbench

Two-master round-robin arbiter sharing one PicoRV32-style valid/ready memory bus. It sits in front of the SoC memory/iomem slave port: master 0 is the CPU, master 1 is the audio DMA engine. Each granted transaction is locked until the slave returns ready. An optional watchdog terminates transactions the slave never answers.

---
 rtl/mem_arbiter2.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - two-master round-robin arbiter on a PicoRV32-style valid/ready memory bus
// Optional slave watchdog enabled by defining TIMEOUT_EN.
module mem_arbiter2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        timeout_err,
    output logic        timeout_master
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   granted, sel, sel_valid, other_valid, tfire, complete;

    always_comb begin
        granted     = (state_q != IDLE);
        sel         = (state_q == GRANT1);
        sel_valid   = sel ? m1_valid : m0_valid;
        other_valid = sel ? m0_valid : m1_valid;
        complete    = granted && (s_ready || tfire);
    end

`ifdef TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        timeout_err_q, timeout_err_d;
    logic        timeout_master_q, timeout_master_d;

    // A slave ready in the expiry cycle wins, so the watchdog only fires on a stalled cycle.
    always_comb tfire = granted && sel_valid && !s_ready && (timer_q == 16'(TIMEOUT));

    always_comb begin
        timer_d          = timer_q;
        timeout_err_d    = timeout_err_q;
        timeout_master_d = timeout_master_q;
        if ((state_d != IDLE) && (state_d != state_q)) begin
            timer_d = '0;
        end else if (granted && !s_ready) begin
            timer_d = timer_q + 16'd1;
        end
        if (tfire) begin
            timeout_err_d    = 1'b1;
            timeout_master_d = sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q          <= '0;
            timeout_err_q    <= 1'b0;
            timeout_master_q <= 1'b0;
        end else begin
            timer_q          <= timer_d;
            timeout_err_q    <= timeout_err_d;
            timeout_master_q <= timeout_master_d;
        end
    end

    assign timeout_err    = timeout_err_q;
    assign timeout_master = timeout_master_q;
`else
    assign tfire          = 1'b0;
    assign timeout_err    = 1'b0;
    assign timeout_master = 1'b0;
`endif

    // A finished grant hands straight to a waiting peer; the same master always passes through IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_valid && (!m1_valid || last_grant_q)) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                end else if (m1_valid) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                if (complete) begin
                    if (other_valid) begin
                        state_d      = sel ? GRANT0 : GRANT1;
                        last_grant_d = !sel;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!sel_valid) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        s_valid  = granted && sel_valid;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        if (granted) begin
            s_addr  = sel ? m1_addr  : m0_addr;
            s_wdata = sel ? m1_wdata : m0_wdata;
            s_wstrb = sel ? m1_wstrb : m0_wstrb;
        end
        m0_ready = complete && !sel;
        m1_ready = complete && sel;
        m0_rdata = (tfire && !sel) ? 32'hFFFF_FFFF : s_rdata;
        m1_rdata = (tfire && sel)  ? 32'hFFFF_FFFF : s_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - scoreboard bench for mem_arbiter2 against a transaction-level arbitration model
module tb_mem_arbiter2;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout_err, timeout_master;

    typedef struct packed {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sw;
        logic [3:0]  ss;
        logic        r0;
        logic        r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        te;
        logic        tm;
    } obs_t;

    int   checks = 0;
    int   passed = 0;
    int   cycle = 0;
    int   completions = 0;
    obs_t exp_q[$];

    int   owner = -1;
    int   last = 1;
    int   stall = 0;
    logic m_te = 1'b0;
    logic m_tm = 1'b0;

    logic rdy0_seen = 1'b0, rdy1_seen = 1'b0;
    int   gap0 = 0, gap1 = 0;
    int   ready_pct = 100;

    always #5 clk = ~clk;

    mem_arbiter2 #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .timeout_err(timeout_err), .timeout_master(timeout_master)
    );

    // Reference model: who owns the bus, whose turn a tie is, and how long the current grant has stalled.
    always @(negedge clk) begin
        obs_t e;
        logic v, ov, fire, done;
        int   pick;
        e = '0;
        fire = 1'b0;
        cycle++;
        if (reset) begin
            owner = -1; last = 1; stall = 0; m_te = 1'b0; m_tm = 1'b0;
            e.d0 = s_rdata;
            e.d1 = s_rdata;
            exp_q.push_back(e);
        end else begin
            v  = (owner == 1) ? m1_valid : m0_valid;
            ov = (owner == 1) ? m0_valid : m1_valid;
`ifdef TIMEOUT_EN
            if (owner >= 0 && v && !s_ready && stall == TO) fire = 1'b1;
`endif
            done = (owner >= 0) && (s_ready || fire);
            if (owner >= 0) begin
                e.sv = v;
                e.sa = (owner == 1) ? m1_addr  : m0_addr;
                e.sw = (owner == 1) ? m1_wdata : m0_wdata;
                e.ss = (owner == 1) ? m1_wstrb : m0_wstrb;
            end
            e.r0 = done && owner == 0;
            e.r1 = done && owner == 1;
            e.d0 = (fire && owner == 0) ? 32'hFFFF_FFFF : s_rdata;
            e.d1 = (fire && owner == 1) ? 32'hFFFF_FFFF : s_rdata;
            e.te = m_te;
            e.tm = m_tm;
            exp_q.push_back(e);
            if (owner < 0) begin
                pick = -1;
                if (m0_valid && m1_valid) pick = 1 - last;
                else if (m0_valid) pick = 0;
                else if (m1_valid) pick = 1;
                if (pick >= 0) begin owner = pick; last = pick; stall = 0; end
            end else if (done) begin
                if (fire) begin m_te = 1'b1; m_tm = (owner == 1); end
                if (ov) begin owner = 1 - owner; last = owner; stall = 0; end
                else owner = -1;
            end else if (!v) begin
                owner = -1;
            end else begin
                stall++;
            end
        end
    end

    always @(negedge clk) begin
        rdy0_seen = m0_ready;
        rdy1_seen = m1_ready;
        #1;
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = {s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, m0_rdata, m1_rdata,
                 timeout_err, timeout_master};
            checks++;
            if (a === e) passed++;
            else $display("FAIL cycle %0d outputs: got %h want %h", cycle, a, e);
            if (a.r0 || a.r1) completions++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic master_step(input logic seen, inout logic valid, inout logic [31:0] addr,
                               inout logic [31:0] wdata, inout logic [3:0] wstrb, inout int gap);
        logic go;
        go = 1'b0;
        if (valid) begin
            if (seen) begin
                gap = int'($urandom_range(0, 3)) - 1;
                if (gap < 0) go = 1'b1;
                else valid = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                valid = 1'b0;
                gap = 0;
            end
        end else if (gap > 0) begin
            gap--;
        end else if ($urandom_range(0, 1) == 1) begin
            go = 1'b1;
        end
        if (go) begin
            valid = 1'b1;
            addr  = $urandom;
            wdata = $urandom;
            wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 0; m1_valid = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_wstrb = 0; m1_wstrb = 0; s_ready = 0; s_rdata = 0;
        repeat (2) cyc();
        chk("reset_s_valid", s_valid, 0);
        chk("reset_s_addr", s_addr, 0);
        chk("reset_ready", {m0_ready, m1_ready}, 0);
        chk("reset_timeout", {timeout_err, timeout_master}, 0);
        reset = 1'b0;

        cyc();
        m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0; s_rdata = 32'h1234_5678;
        #1 chk("read_latency_idle", s_valid, 0);
        cyc();
        chk("read_s_valid", s_valid, 1);
        repeat (3) cyc();
        s_ready = 1;
        #1 chk("read_m0_ready", m0_ready, 1);
        chk("read_rdata", m0_rdata, 32'h1234_5678);
        chk("read_m1_ready", m1_ready, 0);
        cyc();
        m0_valid = 0; s_ready = 0;
        cyc();

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m0_valid = 1; m1_valid = 1; m0_addr = 32'hA000_0000; m1_addr = 32'hB000_0004; s_ready = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_m0_ready", m0_ready, (i % 2) == 0);
            chk("rr_s_addr", s_addr, (i % 2 == 0) ? m0_addr : m1_addr);
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        repeat (2) cyc();

        m1_valid = 1; m1_addr = 32'h0300_0000; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
        cyc();
        chk("wr_s_wstrb", s_wstrb, 4'b0011);
        chk("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
        s_ready = 1;
        cyc();
        m1_valid = 0; s_ready = 0;
        #1 chk("wr_idle_zero", {s_addr, s_wdata, 28'h0, s_wstrb} == '0, 1);
        cyc();

        m1_valid = 1;
        cyc();
        m0_valid = 1; m0_addr = 32'h0000_0400;
        cyc();
        m1_valid = 0;
        #1 chk("abort_s_valid", s_valid, 0);
        cyc();
        chk("abort_idle", s_valid, 0);
        cyc();
        chk("abort_m0_grant", {31'h0, s_valid} + s_addr, 32'h0000_0401);
        s_ready = 1;
        cyc();
        m0_valid = 0; s_ready = 0;
        cyc();

        m0_valid = 1;
        cyc();
        s_ready = 1;
        #1 chk("rst_mid_ready_before", m0_ready, 1);
        #1 reset = 1'b1;
        #1 chk("rst_mid_async", {s_valid, m0_ready, m1_ready}, 0);
        s_ready = 0; m1_valid = 1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_first_tie", s_addr, m0_addr);
        s_ready = 1;
        cyc();
        m0_valid = 0;
        cyc();
        m1_valid = 0; s_ready = 0;
        repeat (2) cyc();

`ifdef TIMEOUT_EN
        m0_valid = 1; m0_addr = 32'h0000_0800;
        cyc();
        m1_valid = 1; m1_addr = 32'h0000_0C00;
        repeat (4) cyc();
        #1 chk("to_m0_ready", m0_ready, 1);
        chk("to_rdata", m0_rdata, 32'hFFFF_FFFF);
        cyc();
        m0_valid = 0;
        #1 chk("to_err", {timeout_err, timeout_master}, 2'b10);
        chk("to_handoff", s_addr, 32'h0000_0C00);
        s_ready = 1;
        cyc();
        m1_valid = 0; s_ready = 0;
        repeat (2) cyc();
`endif

        rdy0_seen = 0; rdy1_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 0) ready_pct = (c == 0) ? 100 : (c == 1000) ? 40 : 12;
            @(posedge clk);
            #1;
            master_step(rdy0_seen, m0_valid, m0_addr, m0_wdata, m0_wstrb, gap0);
            master_step(rdy1_seen, m1_valid, m1_addr, m1_wdata, m1_wstrb, gap1);
            #1;
            s_ready = s_valid && ($urandom_range(0, 99) < ready_pct);
            s_rdata = $urandom;
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        repeat (3) cyc();
        chk("random_completions_seen", completions > 100, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
